cache_arbiter: RTL and testbench
================================

# cache_arbiter

Shares the single 256-bit memory port between the instruction cache and the data cache. Each cache presents its ordinary dfp read/write interface to the arbiter, which grants one cache at a time and forwards its request to memory. The memory response is routed back only to the granted cache. It sits between the two cache instances and the memory model/bus adapter.

## Interface
- No parameters; widths fixed (32-bit address, 256-bit line).
- Clock and reset: one clock; reset is synchronous and active-high.
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- i_dfp_addr  in  32  I-cache line address (bits [4:0] zero)
- i_dfp_read  in  1  I-cache line read request
- i_dfp_write  in  1  I-cache line write request (expected 0; honoured if set)
- i_dfp_wdata  in  256  I-cache write line
- i_dfp_rdata  out  256  read line to I-cache
- i_dfp_resp  out  1  completion to I-cache
- d_dfp_addr / d_dfp_read / d_dfp_write / d_dfp_wdata  in  32/1/1/256  D-cache request, same meaning
- d_dfp_rdata  out  256  read line to D-cache
- d_dfp_resp  out  1  completion to D-cache
- mem_addr  out  32  address to memory
- mem_read  out  1  read request to memory
- mem_write  out  1  write request to memory
- mem_wdata  out  256  write line to memory
- mem_rdata  in  256  read line from memory
- mem_resp  in  1  memory completion, one cycle per transaction

## Operation
- Request pending for port x: x_dfp_read | x_dfp_write. Requesters hold addr/read/write/wdata stable until their resp.
- States: IDLE, SERVE_I, SERVE_D.
- IDLE: all mem_* outputs 0. Only D pending -> SERVE_D. Only I pending -> SERVE_I. Both pending -> grant the port not equal to last_served. None pending -> stay.
- SERVE_x: mem_addr/read/write/wdata are driven combinationally from port x; the other port sees resp=0, rdata=0. mem_resp=1 -> x_dfp_resp=1 and x_dfp_rdata=mem_rdata in the same cycle. last_served<=x and next state IDLE. mem_resp=0 -> stay.
- last_served: 1-bit register. Reset value I, so D wins the first tie. Updated only on completion.
- Read and write both asserted on one port is illegal. The bench flags it with an assertion; RTL forwards both bits unchanged.
- A cache doing write-back then allocate issues two separate transactions. The other cache may be granted between them; that is legal.
- mem_resp in IDLE is ignored and not forwarded. The bench asserts it never occurs.

## Timing
- Reset: state=IDLE, last_served=I. All outputs 0: mem_*, i/d_dfp_resp, i/d_dfp_rdata.
- Reset mid-SERVE: next cycle is IDLE with outputs 0. The in-flight memory transaction is abandoned; no resp is forwarded.
- Request first seen in IDLE at cycle N -> mem_read/mem_write high from N+1 until and including the mem_resp cycle M.
- Resp to the requester in cycle M, combinational from mem_resp. Requester may drop its request at M+1.
- State is IDLE at M+1. The next grant decision is made at M+1, with mem request at M+2.
- Minimum latency from request to resp is 2 cycles (mem_resp at N+1). There is one bubble cycle between back-to-back transactions.
- With both caches continuously requesting, grants strictly alternate (D, I, D, I…). Neither port waits more than one transaction.

## Structure
- Shared package cache_arb_pkg:
  - enum arb_state_t {IDLE, SERVE_I, SERVE_D}
  - enum arb_port_t {PORT_I, PORT_D}
  - localparams LINE_W=256, ADDR_W=32
- Single module; no sub-module needed.
- State and last_served are always_ff; next-state logic and the output mux are one always_comb with all outputs defaulted to 0.

## Test plan
- Reset, no requests: 5 cycles with all outputs 0. Raise rst during SERVE_D -> IDLE next cycle, d_dfp_resp never asserted.
- I-cache read 0x0000_1000 alone, memory responds 3 cycles after mem_read:
  - mem_addr=0x1000 and mem_read=1 from N+1.
  - i_dfp_resp=1 with i_dfp_rdata=mem_rdata in that cycle.
  - d_dfp_resp=0 throughout.
- D-cache write 0x8000_0040 with wdata pattern A5…: mem_write=1, mem_wdata matches, d_dfp_resp on mem_resp, mem_read=0.
- Simultaneous I read 0x100 and D read 0x200 from reset: D served first (mem_addr=0x200). Then I is served (mem_addr=0x100), starting exactly 2 cycles after D's resp.
- Both continuously requesting for 6 transactions: grant order D, I, D, I, D, I; each resp reaches only its own port.
- D write-back 0x40 then allocate 0x80 while I requests 0x300: order is D-write 0x40, I-read 0x300, D-read 0x80.

Source files
------------

// File: rtl/cache_arb_pkg.sv
// cache_arb_pkg
//   Shared types and widths for the I/D cache memory-port arbiter.
//   - arb_state_t : arbiter FSM state (IDLE, SERVE_I, SERVE_D)
//   - arb_port_t  : requester identity, used for the last-served record
//   - LINE_W / ADDR_W : fixed line and address widths
package cache_arb_pkg;

  localparam int LINE_W = 256;
  localparam int ADDR_W = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } arb_port_t;

endpackage

// File: rtl/cache_arbiter.sv
// cache_arbiter
//   Shares one 256-bit memory port between the instruction cache and the
//   data cache. One cache is granted at a time; its request is forwarded to
//   memory and the memory response is routed back only to that cache.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   i_dfp_*  (addr/read/write/wdata in, rdata/resp out)  I-cache side
//   d_dfp_*  (addr/read/write/wdata in, rdata/resp out)  D-cache side
//   mem_*    (addr/read/write/wdata out, rdata/resp in)  memory side
//   dbg_state, dbg_last_served                           FSM observation
//
// Handshake: a port's request is valid while read|write is high, and the
//   requester holds addr/read/write/wdata stable until its resp. resp is a
//   single-cycle completion pulse carrying rdata in the same cycle; the
//   requester may drop or change its request from the following cycle.
//   mem_resp plays the same role toward the arbiter.
module cache_arbiter
  import cache_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,

  input  logic [ADDR_W-1:0] i_dfp_addr,
  input  logic              i_dfp_read,
  input  logic              i_dfp_write,
  input  logic [LINE_W-1:0] i_dfp_wdata,
  output logic [LINE_W-1:0] i_dfp_rdata,
  output logic              i_dfp_resp,

  input  logic [ADDR_W-1:0] d_dfp_addr,
  input  logic              d_dfp_read,
  input  logic              d_dfp_write,
  input  logic [LINE_W-1:0] d_dfp_wdata,
  output logic [LINE_W-1:0] d_dfp_rdata,
  output logic              d_dfp_resp,

  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  output logic              mem_write,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp,

  output arb_state_t        dbg_state,
  output arb_port_t         dbg_last_served
);

  arb_state_t state_q, state_d;
  arb_port_t  last_q, last_d;

  logic i_pend;
  logic d_pend;

  assign i_pend = i_dfp_read | i_dfp_write;
  assign d_pend = d_dfp_read | d_dfp_write;

  assign dbg_state       = state_q;
  assign dbg_last_served = last_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= PORT_I;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  // Next-state and output mux. Everything defaults to 0 so the idle port
  // and the memory side are quiet unless a grant is active. Read and write
  // are forwarded untouched, even if both are set.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    mem_addr    = '0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_wdata   = '0;
    i_dfp_rdata = '0;
    i_dfp_resp  = 1'b0;
    d_dfp_rdata = '0;
    d_dfp_resp  = 1'b0;

    case (state_q)
      IDLE: begin
        // On a tie, grant the port that was not served last; mem_resp
        // arriving here has no owner and is dropped.
        if (d_pend && (!i_pend || last_q == PORT_I)) begin
          state_d = SERVE_D;
        end else if (i_pend) begin
          state_d = SERVE_I;
        end
      end

      SERVE_I: begin
        mem_addr  = i_dfp_addr;
        mem_read  = i_dfp_read;
        mem_write = i_dfp_write;
        mem_wdata = i_dfp_wdata;
        if (mem_resp) begin
          i_dfp_resp  = 1'b1;
          i_dfp_rdata = mem_rdata;
          last_d      = PORT_I;
          state_d     = IDLE;
        end
      end

      SERVE_D: begin
        mem_addr  = d_dfp_addr;
        mem_read  = d_dfp_read;
        mem_write = d_dfp_write;
        mem_wdata = d_dfp_wdata;
        if (mem_resp) begin
          d_dfp_resp  = 1'b1;
          d_dfp_rdata = mem_rdata;
          last_d      = PORT_D;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_cache_arbiter.sv
// tb_cache_arbiter
//   Self-checking bench for cache_arbiter. Two driver tasks play the caches,
//   a behavioural memory answers with a chosen or random latency, and a
//   reference model predicts each granted transaction into exp_q; a monitor
//   compares the DUT against the head of exp_q every cycle.
module tb_cache_arbiter;
  import cache_arb_pkg::*;

  localparam int EXP_W = 3 + ADDR_W + LINE_W;  // {port, rd, wr, addr, wdata}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [ADDR_W-1:0] i_dfp_addr  = '0;
  logic              i_dfp_read  = 1'b0;
  logic              i_dfp_write = 1'b0;
  logic [LINE_W-1:0] i_dfp_wdata = '0;
  logic [LINE_W-1:0] i_dfp_rdata;
  logic              i_dfp_resp;
  logic [ADDR_W-1:0] d_dfp_addr  = '0;
  logic              d_dfp_read  = 1'b0;
  logic              d_dfp_write = 1'b0;
  logic [LINE_W-1:0] d_dfp_wdata = '0;
  logic [LINE_W-1:0] d_dfp_rdata;
  logic              d_dfp_resp;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_read;
  logic              mem_write;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata = '0;
  logic              mem_resp  = 1'b0;
  arb_state_t        dbg_state;
  arb_port_t         dbg_last_served;

  cache_arbiter dut (
    .clk(clk), .rst(rst),
    .i_dfp_addr(i_dfp_addr), .i_dfp_read(i_dfp_read), .i_dfp_write(i_dfp_write),
    .i_dfp_wdata(i_dfp_wdata), .i_dfp_rdata(i_dfp_rdata), .i_dfp_resp(i_dfp_resp),
    .d_dfp_addr(d_dfp_addr), .d_dfp_read(d_dfp_read), .d_dfp_write(d_dfp_write),
    .d_dfp_wdata(d_dfp_wdata), .d_dfp_rdata(d_dfp_rdata), .d_dfp_resp(d_dfp_resp),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .dbg_state(dbg_state), .dbg_last_served(dbg_last_served)
  );

  // ---------------- scoreboard state ----------------
  logic [EXP_W-1:0]  exp_q[$];
  logic [ADDR_W-1:0] done_q[$];   // mem_addr seen at each completion
  logic [ADDR_W-1:0] want_q[$];
  logic              model_last = 1'b0;  // 0 = I served last, 1 = D
  logic              d_resp_seen = 1'b0;
  int n_checks = 0;
  int n_pass   = 0;
  int mem_lat  = -1;              // -1 selects a random latency of 0..3

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] r;
    for (int j = 0; j < LINE_W / 32; j++) r[j*32 +: 32] = $urandom();
    return r;
  endfunction

  // ---------------- memory model ----------------
  int wait_cnt = 0;
  bit mem_active = 1'b0;
  always @(posedge clk) begin
    #2;
    mem_resp = 1'b0;
    if (rst || !(mem_read || mem_write)) begin
      mem_active = 1'b0;
    end else begin
      if (!mem_active) begin
        mem_active = 1'b1;
        wait_cnt = (mem_lat < 0) ? int'($urandom_range(0, 3)) : mem_lat;
      end
      if (wait_cnt == 0) begin
        mem_resp   = 1'b1;
        mem_rdata  = rand_line();
        mem_active = 1'b0;
      end else begin
        wait_cnt--;
      end
    end
  end

  // ---------------- reference model + monitor ----------------
  logic [EXP_W-1:0] e;
  logic ip, dp;

  task automatic chk_idle(input string name);
    chk({name, "_mem"}, {mem_read, mem_write, mem_addr}, '0);
    chk({name, "_wdata"}, mem_wdata, '0);
    chk({name, "_resp"}, {i_dfp_resp, d_dfp_resp}, '0);
    chk({name, "_rdata"}, i_dfp_rdata | d_dfp_rdata, '0);
    chk({name, "_state"}, dbg_state, IDLE);
  endtask

  always @(negedge clk) begin
    if (d_dfp_resp) d_resp_seen = 1'b1;
    if (rst) begin
      if (exp_q.size() != 0) begin
        chk("abandon_resp", {i_dfp_resp, d_dfp_resp}, '0);
      end else begin
        chk_idle("reset");
      end
      exp_q.delete();
      model_last = 1'b0;
    end else begin
      assert (!(i_dfp_read && i_dfp_write)) else $error("illegal read+write on I port");
      assert (!(d_dfp_read && d_dfp_write)) else $error("illegal read+write on D port");
      if (exp_q.size() == 0) begin
        chk_idle("idle");
        chk("resp_in_idle", mem_resp, 1'b0);
        // Grant rule: a lone requester wins; on a tie the port not served last.
        ip = i_dfp_read | i_dfp_write;
        dp = d_dfp_read | d_dfp_write;
        if (dp && (!ip || model_last == 1'b0))
          exp_q.push_back({1'b1, d_dfp_read, d_dfp_write, d_dfp_addr, d_dfp_wdata});
        else if (ip)
          exp_q.push_back({1'b0, i_dfp_read, i_dfp_write, i_dfp_addr, i_dfp_wdata});
      end else begin
        e = exp_q[0];
        chk("mem_addr", mem_addr, e[287:256]);
        chk("mem_rw", {mem_read, mem_write}, e[289:288]);
        chk("mem_wdata", mem_wdata, e[255:0]);
        chk("serve_state", dbg_state, e[290] ? SERVE_D : SERVE_I);
        if (e[290]) begin
          chk("d_resp", d_dfp_resp, mem_resp);
          chk("i_quiet", {i_dfp_resp, i_dfp_rdata}, '0);
          if (mem_resp) chk("d_rdata", d_dfp_rdata, mem_rdata);
        end else begin
          chk("i_resp", i_dfp_resp, mem_resp);
          chk("d_quiet", {d_dfp_resp, d_dfp_rdata}, '0);
          if (mem_resp) chk("i_rdata", i_dfp_rdata, mem_rdata);
        end
        if (mem_resp) begin
          done_q.push_back(mem_addr);
          model_last = e[290];
          void'(exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_i(input logic [31:0] a, input logic w, input logic [255:0] wd, output int lat);
    @(posedge clk); #1;
    i_dfp_addr = a; i_dfp_read = !w; i_dfp_write = w; i_dfp_wdata = wd;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!i_dfp_resp && lat < 200);
    if (!i_dfp_resp) chk("i_resp_timeout", i_dfp_resp, 1'b1);
  endtask

  task automatic drive_d(input logic [31:0] a, input logic w, input logic [255:0] wd, output int lat);
    @(posedge clk); #1;
    d_dfp_addr = a; d_dfp_read = !w; d_dfp_write = w; d_dfp_wdata = wd;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!d_dfp_resp && lat < 200);
    if (!d_dfp_resp) chk("d_resp_timeout", d_dfp_resp, 1'b1);
  endtask

  task automatic drop_i();
    @(posedge clk); #1; i_dfp_read = 1'b0; i_dfp_write = 1'b0;
  endtask

  task automatic drop_d();
    @(posedge clk); #1; d_dfp_read = 1'b0; d_dfp_write = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    i_dfp_read = 1'b0; i_dfp_write = 1'b0; d_dfp_read = 1'b0; d_dfp_write = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    done_q.delete();
  endtask

  task automatic chk_order(input string name);
    chk({name, "_count"}, done_q.size(), want_q.size());
    for (int i = 0; i < want_q.size(); i++)
      if (i < done_q.size()) chk(name, done_q[i], want_q[i]);
  endtask

  // ---------------- stimulus ----------------
  int li, ld;
  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(posedge clk);

    // Reset during SERVE_D: the transaction is abandoned with no resp.
    mem_lat = 10;
    d_resp_seen = 1'b0;
    @(posedge clk); #1;
    d_dfp_addr = 32'h0000_0500; d_dfp_write = 1'b1; d_dfp_wdata = rand_line();
    repeat (3) @(posedge clk);
    #1 rst = 1'b1; d_dfp_write = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) @(posedge clk);
    chk("rst_no_d_resp", d_resp_seen, 1'b0);
    chk("rst_no_completion", done_q.size(), 0);

    // Lone I read, memory answers 3 cycles after mem_read rises.
    do_reset();
    mem_lat = 3;
    drive_i(32'h0000_1000, 1'b0, '0, li);
    drop_i();
    chk("i_read_latency", li, 5);
    want_q = {32'h0000_1000};
    chk_order("i_read_order");

    // Minimum latency: memory answers in the first mem_read cycle.
    mem_lat = 0;
    drive_d(32'h0000_0060, 1'b0, '0, ld);
    drop_d();
    chk("min_latency", ld, 2);

    // D write with A5 pattern.
    mem_lat = -1;
    done_q.delete();
    drive_d(32'h8000_0040, 1'b1, {8{32'hA5A5_A5A5}}, ld);
    drop_d();
    want_q = {32'h8000_0040};
    chk_order("d_write_order");

    // Simultaneous requests from reset: D wins the first tie.
    do_reset();
    fork
      begin drive_i(32'h0000_0100, 1'b0, '0, li); drop_i(); end
      begin drive_d(32'h0000_0200, 1'b0, '0, ld); drop_d(); end
    join
    want_q = {32'h0000_0200, 32'h0000_0100};
    chk_order("tie_order");

    // Both streaming back-to-back: strict alternation.
    do_reset();
    fork
      begin
        for (int k = 0; k < 3; k++) drive_d(32'h0000_2000 + 32'(k * 32), 1'b0, '0, ld);
        drop_d();
      end
      begin
        for (int k = 0; k < 3; k++) drive_i(32'h0000_3000 + 32'(k * 32), 1'b0, '0, li);
        drop_i();
      end
    join
    want_q = {32'h2000, 32'h3000, 32'h2020, 32'h3020, 32'h2040, 32'h3040};
    chk_order("alternate_order");

    // Write-back then allocate on D while I is waiting.
    do_reset();
    fork
      begin
        drive_d(32'h0000_0040, 1'b1, rand_line(), ld);
        drive_d(32'h0000_0080, 1'b0, '0, ld);
        drop_d();
      end
      begin drive_i(32'h0000_0300, 1'b0, '0, li); drop_i(); end
    join
    want_q = {32'h0000_0040, 32'h0000_0300, 32'h0000_0080};
    chk_order("wb_alloc_order");

    // Random traffic on both ports with random gaps and latencies.
    do_reset();
    fork
      begin
        int g;
        for (int k = 0; k < 15; k++) begin
          drive_i($urandom() & 32'hFFFF_FFE0, ($urandom_range(0, 7) == 0), rand_line(), li);
          g = $urandom_range(0, 2);
          if (g > 0) begin drop_i(); repeat (g - 1) @(posedge clk); end
        end
        drop_i();
      end
      begin
        int g;
        for (int k = 0; k < 15; k++) begin
          drive_d($urandom() & 32'hFFFF_FFE0, ($urandom_range(0, 2) == 0), rand_line(), ld);
          g = $urandom_range(0, 2);
          if (g > 0) begin drop_d(); repeat (g - 1) @(posedge clk); end
        end
        drop_d();
      end
    join
    chk("random_count", done_q.size(), 30);

    repeat (4) @(posedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
